muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file. It consumes ReadData1 (rs) and ReadData2 (rt) for MULT, MULTU, DIV and DIVU, and handles MTHI/MTLO.
- HI/LO values are exposed for MFHI/MFLO, which write back through the regfile WriteData path.
- Multicycle: a busy/done handshake lets control stall the pipeline.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; MTHI/MTLO writes accepted here only
//   S_CALC | 32 iterations: shift-add multiply or restoring divide
//   S_FIX  | sign fixup, HI/LO written, done pulse issued next cycle
//
// Operands are reduced to magnitudes at launch so the iteration datapath
// is purely unsigned; signs are re-applied in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              hi_we,
    input  logic              lo_we,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    op_e                 op_q;
    logic                neg_a_q, neg_b_q;
    logic [DATA_W-1:0]   a_mag_q, b_mag_q;
    // Multiply: {accumulator, multiplier}. Divide: low half holds dividend
    // bits shifting out of the top and quotient bits shifting in below.
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                done_q, dbz_q;

    // Launch-time operand decode
    op_e               op_in;
    logic              neg_a_in, neg_b_in;
    logic [DATA_W-1:0] a_mag_in, b_mag_in;

    assign op_in    = op_e'(op);
    assign neg_a_in = is_signed_op(op_in) & rs_data[DATA_W-1];
    assign neg_b_in = is_signed_op(op_in) & rt_data[DATA_W-1];
    assign a_mag_in = neg_a_in ? (~rs_data + 1'b1) : rs_data;
    assign b_mag_in = neg_b_in ? (~rt_data + 1'b1) : rt_data;

    // One iteration step for each operation
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_diff;
    logic              div_fits;

    assign mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                       {1'b0, (prod_q[0] ? a_mag_q : {DATA_W{1'b0}})};
    // 33-bit partial remainder: previous remainder plus next dividend bit
    assign div_shift = {rem_q, prod_q[DATA_W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
    assign div_fits  = ~div_diff[DATA_W+1];

    // Sign fixup and result selection for the FIX cycle
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix, rs_latched;
    logic [DATA_W-1:0]   res_hi, res_lo;
    logic                res_dbz;

    // Pick the signed/unsigned, multiply/divide/zero-divisor result
    always_comb begin
        prod_fix   = (neg_a_q ^ neg_b_q) ? (~prod_q + 1'b1) : prod_q;
        quo_fix    = (neg_a_q ^ neg_b_q) ? (~prod_q[DATA_W-1:0] + 1'b1)
                                         : prod_q[DATA_W-1:0];
        rem_fix    = neg_a_q ? (~rem_q + 1'b1) : rem_q;
        rs_latched = neg_a_q ? (~a_mag_q + 1'b1) : a_mag_q;
        res_dbz    = is_div_op(op_q) && (b_mag_q == '0);
        res_hi     = prod_fix[2*DATA_W-1:DATA_W];
        res_lo     = prod_fix[DATA_W-1:0];
        if (is_div_op(op_q)) begin
            if (res_dbz) begin
                res_hi = rs_latched;
                res_lo = {DATA_W{1'b1}};
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; CALC ends when the down-counter reaches zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO writes and result pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_we) hi_q <= rs_data;
                    if (lo_we) lo_q <= rs_data;
                    if (start) begin
                        op_q    <= op_in;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        a_mag_q <= a_mag_in;
                        b_mag_q <= b_mag_in;
                        cnt_q   <= CNT_W'(ITER_COUNT - 1);
                        rem_q   <= '0;
                        prod_q  <= is_div_op(op_in) ? {{DATA_W{1'b0}}, a_mag_in}
                                                    : {{DATA_W{1'b0}}, b_mag_in};
                    end
                end
                S_CALC: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    if (is_div_op(op_q)) begin
                        rem_q <= div_fits ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                        prod_q[DATA_W-1:0] <= {prod_q[DATA_W-2:0], div_fits};
                    end else begin
                        prod_q <= {mul_sum, prod_q[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dbz_q  <= res_dbz;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        hi_we, lo_we;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] model_hi = 0, model_lo = 0;
    logic [31:0] pend_hi, pend_lo;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model from the architectural definition of each op
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit z);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        z  = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin p = sa * sb; {h, l} = p; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
            2'b10: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; z = 1'b1; end
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; z = 1'b1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (div_by_zero && !done) check("dbz_without_done", div_by_zero, 1'b0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.due));
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_by_zero", div_by_zero, e.dbz);
                end
            end
        end
    end

    // Issue one operation at the next edge; returns just after that edge
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit mtlo);
        exp_t e;
        model(o, a, b, e.hi, e.lo, e.dbz);
        op = o; rs_data = a; rt_data = b; start = 1'b1; lo_we = mtlo;
        @(posedge clock);
        #1;
        e.due = cyc + 33;
        exp_q.push_back(e);
        pend_hi = e.hi;
        pend_lo = e.lo;
        start = 1'b0;
        lo_we = 1'b0;
        if (mtlo) check("mtlo_with_start", lo, a);
    endtask

    // Wait (bounded) for done; busy must stay high until then
    task automatic wait_done();
        bit busy_bad = 1'b0;
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) begin seen = 1'b1; break; end
            if (!busy) busy_bad = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        check("busy_window", busy_bad, 1'b0);
        if (seen) check("busy_after_done", busy, 1'b0);
        model_hi = pend_hi;
        model_lo = pend_lo;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit done_bad;
        reset = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        // Directed cases, back-to-back (each launch happens in the done cycle)
        launch(2'b00, 32'hFFFF_FFFD, 32'd5, 0);        wait_done();
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); wait_done();
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 0);        wait_done();
        launch(2'b11, 32'd100, 32'd7, 0);              wait_done();
        launch(2'b11, 32'd100, 32'd0, 0);              wait_done();
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_done();
        launch(2'b10, 32'hFFFF_FF00, 32'd0, 0);        wait_done();
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 0); wait_done();
        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 0);        wait_done();

        // MTHI / MTLO in IDLE
        @(negedge clock);
        rs_data = 32'hA5A5_0001; hi_we = 1'b1;
        @(posedge clock); #1;
        hi_we = 1'b0;
        check("mthi_idle", hi, 32'hA5A5_0001);
        model_hi = 32'hA5A5_0001;
        @(negedge clock);
        rs_data = 32'h5A5A_0002; lo_we = 1'b1;
        @(posedge clock); #1;
        lo_we = 1'b0;
        check("mtlo_idle", lo, 32'h5A5A_0002);
        model_lo = 32'h5A5A_0002;
        @(negedge clock);

        // MTLO coinciding with start: write lands, result later overwrites
        launch(2'b01, 32'h0001_0000, 32'h0001_0000, 1); wait_done();

        // start and MTHI while busy are ignored
        launch(2'b00, 32'd1234, 32'hFFFF_FF38, 0);
        repeat (4) @(negedge clock);
        start = 1'b1; op = 2'b11; rs_data = 32'd7; rt_data = 32'd3;
        @(negedge clock);
        start = 1'b0; hi_we = 1'b1; rs_data = 32'hDEAD_BEEF;
        @(negedge clock);
        hi_we = 1'b0;
        check("mthi_dropped", hi, model_hi);
        check("busy_mid_op", busy, 1'b1);
        wait_done();

        // Randomized back-to-back operations
        for (int i = 0; i < 30; i++) begin
            launch(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 0);
            wait_done();
        end

        // Reset mid-operation aborts immediately
        launch(2'b10, 32'd1000, 32'd3, 0);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_done", done, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        done_bad = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) done_bad = 1'b1;
        end
        check("no_done_after_abort", done_bad, 1'b0);
        rs_data = 32'h0000_1234; lo_we = 1'b1;
        @(posedge clock); #1;
        lo_we = 1'b0;
        check("mtlo_after_reset", lo, 32'h0000_1234);
        check("hi_after_reset", hi, 32'h0);

        repeat (3) @(negedge clock);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
